// File: rtl/dmem_result_reader_if.sv
// rtl/dmem_result_reader_if.sv - external data-memory port and byte stream bundle for the result reader
interface dmem_result_reader_if;
    logic        hold_cpu;
    logic        Ext_MemWrite;
    logic [31:0] Ext_DataAdr;
    logic [31:0] ReadData;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output hold_cpu,
        output Ext_MemWrite,
        output Ext_DataAdr,
        input  ReadData,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  hold_cpu,
        input  Ext_MemWrite,
        input  Ext_DataAdr,
        output ReadData,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/dmem_result_reader.sv
// rtl/dmem_result_reader.sv - runs the CPU, then dumps a data-memory window as a little-endian byte stream
module dmem_result_reader #(
    parameter int COUNT_W = 8,
    parameter int TIMEOUT = 65535,
    parameter int TMR_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [31:0]        base_adr,
    input  logic [COUNT_W-1:0] word_count,
    input  logic               cpu_done,
    output logic               busy,
    output logic               dump_done,
    output logic               timeout_err,
    dmem_result_reader_if.master bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DONE = 3'd1,
        ADDR      = 3'd2,
        CAPTURE   = 3'd3,
        SEND      = 3'd4,
        FINISH    = 3'd5
    } state_t;

    // The timer value seen on the cycle whose increment reaches TIMEOUT.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t             state, stateNext;
    logic               holdCpu, holdNext;
    logic [31:0]        extAdr, adrNext;
    logic [7:0]         txData, txDataNext;
    logic               txValid, txValidNext;
    logic               busyReg, busyNext;
    logic               dumpDone, dumpDoneNext;
    logic               timeoutErr, timeoutNext;
    logic [29:0]        baseReg, baseNext;
    logic [COUNT_W-1:0] countReg, countNext;
    logic [COUNT_W-1:0] idx, idxNext, idxInc;
    logic [1:0]         bcnt, bcntNext;
    logic [TMR_W-1:0]   timer, timerNext;
    logic [31:0]        shiftReg, shiftNext;

    assign idxInc = idx + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            holdCpu    <= 1'b1;
            extAdr     <= 32'd0;
            txData     <= 8'd0;
            txValid    <= 1'b0;
            busyReg    <= 1'b0;
            dumpDone   <= 1'b0;
            timeoutErr <= 1'b0;
            baseReg    <= 30'd0;
            countReg   <= '0;
            idx        <= '0;
            bcnt       <= 2'd0;
            timer      <= '0;
            shiftReg   <= 32'd0;
        end else begin
            state      <= stateNext;
            holdCpu    <= holdNext;
            extAdr     <= adrNext;
            txData     <= txDataNext;
            txValid    <= txValidNext;
            busyReg    <= busyNext;
            dumpDone   <= dumpDoneNext;
            timeoutErr <= timeoutNext;
            baseReg    <= baseNext;
            countReg   <= countNext;
            idx        <= idxNext;
            bcnt       <= bcntNext;
            timer      <= timerNext;
            shiftReg   <= shiftNext;
        end
    end

    always_comb begin
        stateNext   = state;
        holdNext    = holdCpu;
        adrNext     = extAdr;
        txDataNext  = txData;
        txValidNext = txValid;
        timeoutNext = timeoutErr;
        baseNext    = baseReg;
        countNext   = countReg;
        idxNext     = idx;
        bcntNext    = bcnt;
        timerNext   = timer;
        shiftNext   = shiftReg;

        case (state)
            IDLE: begin
                if (start) begin
                    baseNext    = base_adr[31:2];
                    countNext   = word_count;
                    timeoutNext = 1'b0;
                    idxNext     = '0;
                    timerNext   = '0;
                    if (word_count == '0) begin
                        stateNext = FINISH;
                    end else begin
                        holdNext  = 1'b0;
                        stateNext = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                timerNext = timer + 1'b1;
                if (cpu_done) begin
                    holdNext  = 1'b1;
                    adrNext   = {baseReg, 2'b00};
                    stateNext = ADDR;
                end else if (TIMEOUT != 0 && timer == TMR_LAST) begin
                    timeoutNext = 1'b1;
                    holdNext    = 1'b1;
                    stateNext   = IDLE;
                end
            end
            ADDR: begin
                stateNext = CAPTURE;
            end
            CAPTURE: begin
                shiftNext   = bus.ReadData;
                bcntNext    = 2'd0;
                txDataNext  = bus.ReadData[7:0];
                txValidNext = 1'b1;
                stateNext   = SEND;
            end
            SEND: begin
                if (txValid && bus.tx_ready) begin
                    if (bcnt != 2'd3) begin
                        // Shift so the next byte is always at [15:8] when it is needed.
                        bcntNext   = bcnt + 2'd1;
                        shiftNext  = {8'h00, shiftReg[31:8]};
                        txDataNext = shiftReg[15:8];
                    end else begin
                        txValidNext = 1'b0;
                        idxNext     = idxInc;
                        if (idxInc == countReg) begin
                            stateNext = FINISH;
                        end else begin
                            adrNext   = extAdr + 32'd4;
                            stateNext = ADDR;
                        end
                    end
                end
            end
            FINISH: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        dumpDoneNext = (state == FINISH);
        busyNext     = (stateNext != IDLE);
    end

    assign bus.hold_cpu     = holdCpu;
    assign bus.Ext_MemWrite = 1'b0;
    assign bus.Ext_DataAdr  = extAdr;
    assign bus.tx_data      = txData;
    assign bus.tx_valid     = txValid;
    assign busy             = busyReg;
    assign dump_done        = dumpDone;
    assign timeout_err      = timeoutErr;

endmodule

// File: tb/tb_dmem_result_reader.sv
// tb/tb_dmem_result_reader.sv - scoreboard bench for the data-memory result reader
module tb_dmem_result_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_adr = 32'd0;
    logic [7:0]  word_count = 8'd0;
    logic        cpu_done = 1'b0;
    logic        busy, dump_done, timeout_err;

    dmem_result_reader_if bus ();

    dmem_result_reader #(.COUNT_W(8), .TIMEOUT(20), .TMR_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_adr    (base_adr),
        .word_count  (word_count),
        .cpu_done    (cpu_done),
        .busy        (busy),
        .dump_done   (dump_done),
        .timeout_err (timeout_err),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memRead(input logic [31:0] a);
        case (a)
            32'h0000_0010: memRead = 32'h1122_3344;
            32'h0000_0014: memRead = 32'hAABB_CCDD;
            32'hFFFF_FFFC: memRead = 32'hDEAD_BEEF;
            32'h0000_0000: memRead = 32'h0123_4567;
            default:       memRead = {a[15:0], ~a[15:0]};
        endcase
    endfunction

    assign bus.ReadData = memRead(bus.Ext_DataAdr);
    logic txReady = 1'b1;
    assign bus.tx_ready = txReady;

    typedef struct {
        logic [31:0] adr;
        logic [7:0]  b;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad = 0;
    int   dumpCnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushWord(input logic [31:0] adr, input logic [31:0] data);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.adr = adr;
            e.b   = data[8*i +: 8];
            expQ.push_back(e);
        end
    endtask

    task automatic startRun(input logic [31:0] b, input logic [7:0] n);
        start      = 1'b1;
        base_adr   = b;
        word_count = n;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDump(input bit bp);
        int i;
        i = 0;
        while (dumpCnt == 0 && i < 400) begin
            if (bp) txReady = (i % 4 == 0) || (i % 4 == 3);
            tick();
            i++;
        end
        if (dumpCnt == 0) begin
            bad++;
            total++;
            $display("FAIL dump_wait actual=timeout required=dump_done");
        end
        txReady = 1'b1;
        tick();
        tick();
        chk("dump_pulses", dumpCnt, 1);
        chk("queue_empty", expQ.size(), 0);
        chk("busy_after", busy, 1'b0);
        chk("hold_after", bus.hold_cpu, 1'b1);
        dumpCnt = 0;
    endtask

    task automatic waitValid();
        int i;
        i = 0;
        while (!bus.tx_valid && i < 100) begin
            tick();
            i++;
        end
        chk("tx_valid_wait", bus.tx_valid, 1'b1);
    endtask

    // Monitor: pops the scoreboard on every accepted byte and checks hold-under-backpressure.
    logic       prevValid = 1'b0;
    logic       prevReady = 1'b0;
    logic [7:0] prevData = 8'd0;

    always @(negedge clk) begin
        if (!reset) begin
            prevValid = 1'b0;
        end else begin
            chk("mem_write", bus.Ext_MemWrite, 1'b0);
            if (prevValid && !prevReady) begin
                chk("hold_valid", bus.tx_valid, 1'b1);
                chk("hold_data", bus.tx_data, prevData);
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (expQ.size() == 0) begin
                    chk("unexpected_byte", bus.tx_data, 32'hxxxx_xxxx);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    chk("tx_data", bus.tx_data, e.b);
                    chk("ext_adr", bus.Ext_DataAdr, e.adr);
                end
            end
            if (dump_done) dumpCnt++;
            prevValid = bus.tx_valid;
            prevReady = bus.tx_ready;
            prevData  = bus.tx_data;
        end
    end

    initial begin
        tick();
        tick();
        chk("rst_hold", bus.hold_cpu, 1'b1);
        chk("rst_adr", bus.Ext_DataAdr, 32'd0);
        chk("rst_txvalid", bus.tx_valid, 1'b0);
        chk("rst_txdata", bus.tx_data, 8'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", dump_done, 1'b0);
        chk("rst_tmo", timeout_err, 1'b0);
        reset = 1'b1;
        tick();

        // Basic dump
        pushWord(32'h10, 32'h1122_3344);
        pushWord(32'h14, 32'hAABB_CCDD);
        startRun(32'h10, 8'd2);
        chk("basic_hold_fall", bus.hold_cpu, 1'b0);
        chk("basic_busy", busy, 1'b1);
        repeat (4) tick();
        chk("basic_hold_low", bus.hold_cpu, 1'b0);
        cpu_done = 1'b1;
        tick();
        chk("basic_hold_rise", bus.hold_cpu, 1'b1);
        chk("basic_adr", bus.Ext_DataAdr, 32'h10);
        cpu_done = 1'b0;
        waitDump(1'b0);

        // Backpressure
        pushWord(32'h10, 32'h1122_3344);
        pushWord(32'h14, 32'hAABB_CCDD);
        startRun(32'h10, 8'd2);
        repeat (4) tick();
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        waitDump(1'b1);

        // Zero count
        startRun(32'h10, 8'd0);
        chk("zero_done_early", dump_done, 1'b0);
        chk("zero_hold1", bus.hold_cpu, 1'b1);
        tick();
        chk("zero_done_pulse", dump_done, 1'b1);
        chk("zero_hold2", bus.hold_cpu, 1'b1);
        chk("zero_txvalid", bus.tx_valid, 1'b0);
        tick();
        chk("zero_done_end", dump_done, 1'b0);
        chk("zero_busy", busy, 1'b0);
        dumpCnt = 0;

        // Timeout
        startRun(32'h10, 8'd1);
        repeat (19) tick();
        chk("tmo_early", timeout_err, 1'b0);
        chk("tmo_busy_early", busy, 1'b1);
        tick();
        chk("tmo_flag", timeout_err, 1'b1);
        chk("tmo_hold", bus.hold_cpu, 1'b1);
        chk("tmo_busy", busy, 1'b0);
        repeat (3) tick();
        chk("tmo_sticky", timeout_err, 1'b1);
        chk("tmo_no_done", dumpCnt, 0);
        pushWord(32'h10, 32'h1122_3344);
        startRun(32'h10, 8'd1);
        chk("tmo_cleared", timeout_err, 1'b0);
        repeat (2) tick();
        cpu_done = 1'b1;
        tick();
        cpu_done = 1'b0;
        waitDump(1'b0);

        // Wrap, low address bits ignored, start ignored while busy
        pushWord(32'hFFFF_FFFC, 32'hDEAD_BEEF);
        pushWord(32'h0000_0000, 32'h0123_4567);
        cpu_done = 1'b1;
        startRun(32'hFFFF_FFFF, 8'd2);
        waitValid();
        tick();
        startRun(32'h40, 8'd3);
        cpu_done = 1'b0;
        waitDump(1'b0);
        chk("wrap_tmo", timeout_err, 1'b0);

        // Reset mid-SEND
        pushWord(32'h10, 32'h1122_3344);
        pushWord(32'h14, 32'hAABB_CCDD);
        txReady  = 1'b0;
        cpu_done = 1'b1;
        startRun(32'h10, 8'd2);
        waitValid();
        #2;
        reset = 1'b0;
        #1;
        chk("rstmid_txvalid", bus.tx_valid, 1'b0);
        chk("rstmid_hold", bus.hold_cpu, 1'b1);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_adr", bus.Ext_DataAdr, 32'd0);
        expQ.delete();
        cpu_done = 1'b0;
        txReady  = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        tick();
        chk("rstrel_busy", busy, 1'b0);
        chk("rstrel_txvalid", bus.tx_valid, 1'b0);
        chk("rstrel_hold", bus.hold_cpu, 1'b1);
        chk("rstrel_done", dump_done, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_result_reader.md
Name: dmem_result_reader

Overview:
- Reads back a window of data memory after a program run and streams it out as bytes.
- Sits beside the CPU top level and drives its external memory port: hold_cpu feeds the CPU top's reset input, Ext_DataAdr addresses memory, and ReadData is sampled.
- It is the read-side counterpart of the external load path: it waits for cpu_done, freezes the CPU, walks base..base+4*(N-1), and serialises each word little-endian over a valid/ready byte stream.

Parameters:
- COUNT_W, 8: width of the word_count input; maximum dump is 2^COUNT_W-1 words.
- TIMEOUT, 65535: maximum cycles to wait for cpu_done. 0 disables the timeout.
- TMR_W, 16: width of the timeout counter. Must satisfy TIMEOUT < 2^TMR_W.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  single-cycle request to begin a run-and-dump.
- base_adr  in  32  byte address of the first word; must be word-aligned.
- word_count  in  COUNT_W  number of 32-bit words to dump.
- cpu_done  in  1  CPU completion flag from the CPU top.
- ReadData  in  32  data memory read data; combinational from Ext_DataAdr while the CPU is held.
- hold_cpu  out  1  1 holds the CPU in reset and selects the external address path.
- Ext_MemWrite  out  1  tied 0; this block never writes memory.
- Ext_DataAdr  out  32  external read address.
- tx_data  out  8  output byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  consumer accepts the byte.
- busy  out  1  high in any state other than IDLE.
- dump_done  out  1  one-cycle pulse when the last byte is accepted.
- timeout_err  out  1  sticky flag: cpu_done never arrived.

Behaviour:
- Reset values (asynchronous, while reset=0): state=IDLE, hold_cpu=1, Ext_DataAdr=0, tx_data=0, tx_valid=0, busy=0, dump_done=0, timeout_err=0, all counters 0.
- All outputs are registered. tx_valid drops immediately on reset assertion, including mid-byte.
- States: IDLE, WAIT_DONE, ADDR, CAPTURE, SEND, FINISH.
- IDLE:
  - start=1 latches base_adr and word_count, clears timeout_err, and sets word index idx=0.
  - If word_count=0: go to FINISH. hold_cpu stays 1; no bytes are sent.
  - Otherwise: hold_cpu<=0 (CPU runs) and go to WAIT_DONE.
  - start while not IDLE is ignored.
- WAIT_DONE:
  - Each cycle, the timer increments.
  - If cpu_done=1: hold_cpu<=1, Ext_DataAdr<=base, go to ADDR. If cpu_done is already high on entry, this happens on the first WAIT_DONE cycle.
  - Else if TIMEOUT!=0 and timer reaches TIMEOUT: timeout_err<=1, hold_cpu<=1, go to IDLE. No dump_done pulse.
- ADDR: one settle cycle while the address and hold propagate. Go to CAPTURE.
- CAPTURE:
  - shift_reg<=ReadData, byte counter bcnt=0.
  - tx_data<=ReadData[7:0], tx_valid<=1, go to SEND.
- SEND:
  - tx_data and tx_valid stay stable until tx_valid&&tx_ready.
  - On a handshake with bcnt<3: bcnt++, tx_data<=next byte (bits [15:8], then [23:16], then [31:24]).
  - On a handshake with bcnt=3: tx_valid<=0 and idx++.
    - If idx+1=count: go to FINISH.
    - Else: Ext_DataAdr<=base+4*(idx+1), go to ADDR.
  - Throughput: max one byte per cycle. Each word costs 2 overhead cycles (ADDR, CAPTURE).
- FINISH: dump_done=1 for exactly one cycle, then IDLE. hold_cpu remains 1 until the next accepted start.
- Address arithmetic is modulo 2^32: base 0xFFFFFFFC followed by the next word gives 0x00000000. base_adr[1:0] are ignored (forced 00).
- Ext_MemWrite is constant 0 in every state.
- cpu_done deasserting after it was seen has no effect. ReadData is sampled only in CAPTURE.

Test Plan:
- Basic dump:
  - Stimulus: preload mem[0x10]=0x11223344, mem[0x14]=0xAABBCCDD; start with base=0x10, count=2; cpu_done rises 5 cycles later; tx_ready=1.
  - Required: hold_cpu falls the cycle after start and rises the cycle after cpu_done. Bytes are 44 33 22 11 DD CC BB AA. dump_done pulses once. Ext_MemWrite stays 0 throughout.
- Backpressure:
  - Stimulus: same run with tx_ready toggling 1-0-0-1.
  - Required: tx_data/tx_valid are held stable while ready=0. Same 8 bytes, no duplicates, no drops.
- Zero count:
  - Stimulus: start with count=0.
  - Required: dump_done pulses 2 cycles after start. hold_cpu never drops. tx_valid never rises.
- Timeout:
  - Stimulus: TIMEOUT=20, cpu_done held 0.
  - Required: timeout_err=1 about 20 cycles after start, hold_cpu=1, busy=0, no dump_done. A new start clears timeout_err.
- Wrap and ignored start:
  - Stimulus: base=0xFFFFFFFC, count=2; pulse start again mid-SEND.
  - Required: Ext_DataAdr goes 0xFFFFFFFC then 0x00000000. The second start has no effect.
- Reset mid-SEND:
  - Stimulus: assert reset=0 asynchronously while tx_valid=1.
  - Required: tx_valid=0 and hold_cpu=1 immediately. After release: IDLE, busy=0.
